// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if: request/response bundle between a requester and multicycle_alu.
//   master: drives start, opcode, operand_x, operand_y; observes result/status.
//   slave : the ALU; observes the request, drives result, acc_write, busy, done, flags.
interface multicycle_alu_if;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 4;

    logic              start;
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] operand_x;
    logic [DATA_W-1:0] operand_y;
    logic [DATA_W-1:0] result;
    logic              acc_write;
    logic              busy;
    logic              done;
    logic              flag_z;
    logic              flag_n;
    logic              flag_c;
    logic              flag_v;
    logic              flag_err;

    modport master (
        output start, opcode, operand_x, operand_y,
        input  result, acc_write, busy, done,
        input  flag_z, flag_n, flag_c, flag_v, flag_err
    );

    modport slave (
        input  start, opcode, operand_x, operand_y,
        output result, acc_write, busy, done,
        output flag_z, flag_n, flag_c, flag_v, flag_err
    );
endinterface

// File: rtl/multicycle_alu.sv
// multicycle_alu: 16-bit unsigned ALU. Most ops complete in one cycle; MUL
// (shift-add) and DIV/MOD (restoring) take 16 iterations.
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : multicycle_alu_if.slave -- start/opcode/operands in; result, flags,
//         busy, done and the accumulator write strobe (acc_write) out.
module multicycle_alu (
    input  logic             clk,
    input  logic             rst,
    multicycle_alu_if.slave  bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned CNT_W  = 5;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [OP_W-1:0] OP_ADD   = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB   = 4'h1;
    localparam logic [OP_W-1:0] OP_AND   = 4'h2;
    localparam logic [OP_W-1:0] OP_OR    = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR   = 4'h4;
    localparam logic [OP_W-1:0] OP_NOT   = 4'h5;
    localparam logic [OP_W-1:0] OP_SHL   = 4'h6;
    localparam logic [OP_W-1:0] OP_SHR   = 4'h7;
    localparam logic [OP_W-1:0] OP_INC   = 4'h8;
    localparam logic [OP_W-1:0] OP_DEC   = 4'h9;
    localparam logic [OP_W-1:0] OP_MUL   = 4'hA;
    localparam logic [OP_W-1:0] OP_DIV   = 4'hB;
    localparam logic [OP_W-1:0] OP_MOD   = 4'hC;
    localparam logic [OP_W-1:0] OP_PASSX = 4'hD;

    localparam logic [CNT_W-1:0] LAST_ITER = 5'd15;

    // State and datapath registers
    logic [1:0]        state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic [DATA_W-1:0] y_q, y_d;
    logic [DATA_W-1:0] hi_q, hi_d;     // MUL: product high half; DIV/MOD: remainder
    logic [DATA_W-1:0] lo_q, lo_d;     // MUL: multiplier/product low; DIV/MOD: dividend/quotient
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, err_q, err_d;
    logic              done_q, done_d, acc_q, acc_d, busy_q, busy_d;

    // Single-cycle datapath, fed straight from the request inputs
    logic [DATA_W:0]   add_w, sub_w, inc_w, dec_w;
    logic [DATA_W-1:0] sc_res;
    logic              sc_c, sc_v, sc_err;
    logic              is_multi;

    assign add_w = {1'b0, bus.operand_x} + {1'b0, bus.operand_y};
    assign sub_w = {1'b0, bus.operand_x} - {1'b0, bus.operand_y};
    assign inc_w = {1'b0, bus.operand_x} + 17'd1;
    assign dec_w = {1'b0, bus.operand_x} - 17'd1;

    // Divide by zero is resolved in one cycle rather than iterating
    assign is_multi = (bus.opcode == OP_MUL) ||
                      (((bus.opcode == OP_DIV) || (bus.opcode == OP_MOD)) &&
                       (bus.operand_y != '0));

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_err = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                sc_res = add_w[DATA_W-1:0];
                sc_c   = add_w[DATA_W];
                sc_v   = (bus.operand_x[15] == bus.operand_y[15]) &&
                         (add_w[15] != bus.operand_x[15]);
            end
            OP_SUB: begin
                sc_res = sub_w[DATA_W-1:0];
                sc_c   = sub_w[DATA_W];
                sc_v   = (bus.operand_x[15] != bus.operand_y[15]) &&
                         (sub_w[15] != bus.operand_x[15]);
            end
            OP_AND:   sc_res = bus.operand_x & bus.operand_y;
            OP_OR:    sc_res = bus.operand_x | bus.operand_y;
            OP_XOR:   sc_res = bus.operand_x ^ bus.operand_y;
            OP_NOT:   sc_res = ~bus.operand_x;
            OP_SHL: begin
                sc_res = {bus.operand_x[14:0], 1'b0};
                sc_c   = bus.operand_x[15];
            end
            OP_SHR: begin
                sc_res = {1'b0, bus.operand_x[15:1]};
                sc_c   = bus.operand_x[0];
            end
            OP_INC: begin
                sc_res = inc_w[DATA_W-1:0];
                sc_c   = inc_w[DATA_W];
                sc_v   = ~bus.operand_x[15] & inc_w[15];
            end
            OP_DEC: begin
                sc_res = dec_w[DATA_W-1:0];
                sc_c   = dec_w[DATA_W];
                sc_v   = bus.operand_x[15] & ~dec_w[15];
            end
            OP_DIV: begin
                sc_res = 16'hFFFF;
                sc_err = 1'b1;
            end
            OP_MOD: begin
                sc_res = bus.operand_x;
                sc_err = 1'b1;
            end
            OP_PASSX: sc_res = bus.operand_x;
            OP_MUL:   sc_res = '0;
            default:  sc_err = 1'b1;
        endcase
    end

    // One iteration of shift-add multiply: add multiplicand if LSB set, shift right
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W-1:0] mul_hi, mul_lo;

    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, x_q} : 17'd0);
    assign mul_hi  = mul_sum[DATA_W:1];
    assign mul_lo  = {mul_sum[0], lo_q[DATA_W-1:1]};

    // One iteration of restoring division: shift in next dividend bit, trial subtract
    logic [DATA_W:0]   div_sh;
    logic              div_ge;
    logic [DATA_W-1:0] div_hi, div_lo;

    assign div_sh = {hi_q, lo_q[DATA_W-1]};
    assign div_ge = (div_sh >= {1'b0, y_q});
    assign div_hi = div_ge ? (div_sh[DATA_W-1:0] - y_q) : div_sh[DATA_W-1:0];
    assign div_lo = {lo_q[DATA_W-2:0], div_ge};

    logic [DATA_W-1:0] it_hi, it_lo, fin_res;
    logic              fin_v;

    assign it_hi   = (op_q == OP_MUL) ? mul_hi : div_hi;
    assign it_lo   = (op_q == OP_MUL) ? mul_lo : div_lo;
    assign fin_res = (op_q == OP_MUL) ? mul_lo :
                     (op_q == OP_DIV) ? div_lo : div_hi;
    assign fin_v   = (op_q == OP_MUL) && (mul_hi != '0);

    // Next-state and register-update logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        z_d     = z_q;
        n_d     = n_q;
        c_d     = c_q;
        v_d     = v_q;
        err_d   = err_q;
        done_d  = 1'b0;
        acc_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d = bus.opcode;
                    x_d  = bus.operand_x;
                    y_d  = bus.operand_y;
                    if (is_multi) begin
                        state_d = ITER;
                        cnt_d   = '0;
                        hi_d    = '0;
                        lo_d    = (bus.opcode == OP_MUL) ? bus.operand_y : bus.operand_x;
                    end else begin
                        state_d = DONE;
                        res_d   = sc_res;
                        z_d     = (sc_res == '0);
                        n_d     = sc_res[DATA_W-1];
                        c_d     = sc_c;
                        v_d     = sc_v;
                        err_d   = sc_err;
                        done_d  = 1'b1;
                        acc_d   = 1'b1;
                    end
                end
            end
            ITER: begin
                hi_d  = it_hi;
                lo_d  = it_lo;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    res_d   = fin_res;
                    z_d     = (fin_res == '0);
                    n_d     = fin_res[DATA_W-1];
                    c_d     = 1'b0;
                    v_d     = fin_v;
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                    acc_d   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            acc_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            v_q     <= v_d;
            err_q   <= err_d;
            done_q  <= done_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.result    = res_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_n    = n_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_v    = v_q;
    assign bus.flag_err  = err_q;
    assign bus.done      = done_q;
    assign bus.acc_write = acc_q;
    assign bus.busy      = busy_q;
endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have input clk, 1 bit: system clock; all state changes on the rising edge.
REQ-002 The block SHALL have input rst, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have input start, 1 bit: operation request; sampled only in IDLE.
REQ-004 The block SHALL have input opcode, 4 bits: operation select, encoding per REQ-014.
REQ-005 The block SHALL have inputs operand_x and operand_y, 16 bits each: operands taken from register X and register Y read ports.
REQ-006 The block SHALL have output result, 16 bits, registered: result of the last completed operation; feeds the accumulator write data.
REQ-007 The block SHALL have output acc_write, 1 bit: one-cycle strobe, asserted together with done; drives the accumulator write enable.
REQ-008 The block SHALL have outputs busy and done, 1 bit each: busy = state is not IDLE; done = one-cycle completion pulse.
REQ-009 The block SHALL have outputs flag_z, flag_n, flag_c, flag_v and flag_err, 1 bit each, registered: zero, negative, carry, overflow and error.

Function
REQ-010 The block SHALL implement FSM states IDLE, ITER and DONE.
REQ-011 In IDLE with start=1, the block SHALL latch opcode, operand_x and operand_y at that edge (E0); start in ITER or DONE SHALL be ignored, with no queueing.
REQ-012 Single-cycle ops SHALL register result and flags at E0 and go to DONE; done and acc_write SHALL be high for the cycle after E0 (latency 1).
REQ-013 MUL, DIV and MOD SHALL go from E0 to ITER and run 16 iterations, one per edge (E1..E16), with a 5-bit counter; at E16 result and flags SHALL be registered and the FSM SHALL go to DONE (latency 17).
REQ-014 Opcodes SHALL be: 0 ADD x+y, 1 SUB x-y, 2 AND, 3 OR, 4 XOR, 5 NOT x, 6 SHL x<<1, 7 SHR x>>1 (logical), 8 INC x+1, 9 DEC x-1, A MUL, B DIV, C MOD, D PASSX (result=x). All ops SHALL be unsigned, modulo 2^16.
REQ-015 MUL SHALL be shift-add, 32-bit product; result = product[15:0]; flag_v=1 iff product[31:16]!=0.
REQ-016 DIV/MOD SHALL be restoring division; DIV result = quotient, MOD result = remainder.
REQ-017 DIV or MOD with operand_y=0 SHALL take the single-cycle path: DIV result=16'hFFFF, MOD result=operand_x, flag_err=1.
REQ-018 Opcodes E and F SHALL take the single-cycle path with result=0 and flag_err=1; they SHALL still pulse acc_write.
REQ-019 flag_z SHALL equal (result==0) and flag_n SHALL equal result[15], for every op.
REQ-020 flag_c SHALL be: ADD/INC carry-out; SUB/DEC borrow; SHL x[15]; SHR x[0]; 0 for all other ops.
REQ-021 flag_v SHALL be signed overflow for ADD/SUB/INC/DEC, per REQ-015 for MUL, and 0 for all other ops; flag_err SHALL be 0 except per REQ-017/018.
REQ-022 DONE SHALL go to IDLE unconditionally at the next edge; a start high in DONE SHALL be ignored, and the earliest accepted start is the next cycle in IDLE.
REQ-023 result and flags SHALL hold their values until the next completion; operand changes during ITER SHALL have no effect.

Reset
REQ-024 While rst=0, the block SHALL be in IDLE with result=0, all flags=0, busy=0, done=0, acc_write=0, counter=0 and internal operand/partial registers=0.
REQ-025 Reset asserted mid-ITER SHALL abort the operation immediately; no done or acc_write pulse SHALL follow its release.
REQ-026 After rst release, the first rising edge SHALL be able to accept start.

Verification
REQ-027 ADD x=FFFF, y=0001 -> one cycle later: done=acc_write=1 for 1 cycle, result=0000, z=1, c=1, v=0, busy back to 0 the following cycle.
REQ-028 MUL x=0100, y=0100 -> done exactly 17 cycles after start edge, result=0000, v=1, z=1; busy high for cycles 1..17; MUL 00FF*0101 -> result=FFFF, v=0, n=1.
REQ-029 DIV x=A5A5, y=0010 -> result=0A5A after 17 cycles; MOD same operands -> result=0005; DIV x=1234, y=0 -> result=FFFF, err=1, latency 1.
REQ-030 start held high continuously with SUB x=0005, y=0007 -> result=FFFE, c=1, n=1; accepted once per 2 cycles (IDLE, DONE alternating); starts during ITER of a MUL are dropped.
REQ-031 rst pulsed low at cycle 8 of a DIV -> all outputs 0 immediately, no done after release, then the next ADD 1234+5A5A -> 6C8E.
REQ-032 opcode F -> result=0000, err=1, z=1, acc_write pulsed; subsequent PASSX x=BEEF -> result=BEEF, err=0, n=1.
